// File: rtl/apb_ral_pkg.sv
// Shared constants for the apb_ral register slave and its arbiter.
// FSM encodings plus the slave's register map.
package apb_ral_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_SETUP    = 3'd1;
  localparam state_t ST_ACCESS   = 3'd2;
  localparam state_t ST_RDWAIT   = 3'd3;
  localparam state_t ST_COMPLETE = 3'd4;

  localparam logic [31:0] ADDR_CNTRL = 32'h0;
  localparam logic [31:0] ADDR_REG1  = 32'h4;
  localparam logic [31:0] ADDR_REG2  = 32'h8;
  localparam logic [31:0] ADDR_REG3  = 32'hC;
  localparam logic [31:0] ADDR_REG4  = 32'h10;

  localparam int CNTRL_W = 4;

endpackage

// File: rtl/apb_ral_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr.
// Ports: req, ptr in; one-hot grant and its index out.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = PW + 1;

  logic [SW-1:0] sum;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(NUM_REQ))
        sum = sum - SW'(NUM_REQ);
      if (!found && req[sum[PW-1:0]]) begin
        found              = 1'b1;
        grant[sum[PW-1:0]] = 1'b1;
        idx                = sum[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/apb_ral_arbiter.sv
// APB master sharing apb_ral among NUM_REQ requesters, round-robin.
// Ports: req/req_* in, done/rdata/busy out, APB master bus to slave.
module apb_ral_arbiter
  import apb_ral_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata
);

  localparam int PW = $clog2(NUM_REQ);

  state_t               state;
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        win;
  logic [NUM_REQ-1:0]   win_oh;
  logic [NUM_REQ-1:0]   gnt;
  logic [PW-1:0]        gidx;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req  (req),
    .ptr  (ptr),
    .grant(gnt),
    .idx  (gidx)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      win     <= '0;
      win_oh  <= '0;
      done    <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|req) begin
            state  <= ST_SETUP;
            busy   <= 1'b1;
            psel   <= 1'b1;
            win    <= gidx;
            win_oh <= gnt;
            pwrite <= req_write[gidx];
            paddr  <= req_addr[int'(gidx)*ADDR_W +: ADDR_W];
            pwdata <= req_wdata[int'(gidx)*DATA_W +: DATA_W];
          end
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          penable <= 1'b1;
        end
        ST_ACCESS: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          // Slave has no pready: write is committed now, read data
          // appears on prdata one cycle later.
          if (pwrite) begin
            state <= ST_COMPLETE;
            done  <= win_oh;
          end else begin
            state <= ST_RDWAIT;
          end
        end
        ST_RDWAIT: begin
          state <= ST_COMPLETE;
          rdata <= prdata;
          done  <= win_oh;
        end
        ST_COMPLETE: begin
          state <= ST_IDLE;
          done  <= '0;
          busy  <= 1'b0;
          if (win == PW'(NUM_REQ - 1))
            ptr <= '0;
          else
            ptr <= win + PW'(1);
        end
        default: begin
          state   <= ST_IDLE;
          done    <= '0;
          busy    <= 1'b0;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_ral_arbiter.sv
// Directed bench: arbiter driving a behavioural apb_ral slave.
// Requesters are driven per scenario; APB rules checked each cycle.
module tb_apb_ral_arbiter;
  import apb_ral_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            pclk = 1'b0;
  logic            presetn;
  logic            srst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    done;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [DW-1:0]   prdata;

  logic [CNTRL_W-1:0] m_cntrl;
  logic [31:0]        m_reg1, m_reg2, m_reg3, m_reg4;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  logic [N-1:0] hold;
  int done_log[$];
  int done_cyc[$];

  always #5 pclk = ~pclk;

  apb_ral_arbiter #(
    .NUM_REQ(N),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .pclk     (pclk),
    .presetn  (presetn),
    .req      (req),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .done     (done),
    .rdata    (rdata),
    .busy     (busy),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata)
  );

  // apb_ral model: write commits at end of ACCESS, read reg loads then.
  always_ff @(posedge pclk or negedge srst_n) begin
    if (!srst_n) begin
      m_cntrl <= '0;
      m_reg1  <= '0;
      m_reg2  <= '0;
      m_reg3  <= '0;
      m_reg4  <= '0;
      prdata  <= '0;
    end else if (psel && penable) begin
      if (pwrite) begin
        if (paddr == ADDR_CNTRL) m_cntrl <= pwdata[CNTRL_W-1:0];
        if (paddr == ADDR_REG1)  m_reg1  <= pwdata;
        if (paddr == ADDR_REG2)  m_reg2  <= pwdata;
        if (paddr == ADDR_REG3)  m_reg3  <= pwdata;
        if (paddr == ADDR_REG4)  m_reg4  <= pwdata;
      end else begin
        if (paddr == ADDR_CNTRL)
          prdata <= {{(32-CNTRL_W){1'b0}}, m_cntrl};
        else if (paddr == ADDR_REG1) prdata <= m_reg1;
        else if (paddr == ADDR_REG2) prdata <= m_reg2;
        else if (paddr == ADDR_REG3) prdata <= m_reg3;
        else if (paddr == ADDR_REG4) prdata <= m_reg4;
        else prdata <= '0;
      end
    end
  end

  task automatic tick();
    @(negedge pclk);
    cyc++;
    total_cnt++;
    if ((penable && !psel) || ($countones(done) > 1))
      $display("FAIL apb_protocol cyc=%0d psel=%b penable=%b done=%b",
               cyc, psel, penable, done);
    else
      pass_cnt++;
    if (done != '0) begin
      for (int j = 0; j < N; j++) begin
        if (done[j]) begin
          done_log.push_back(j);
          done_cyc.push_back(cyc);
          if (!hold[j]) req[j] = 1'b0;
        end
      end
    end
  endtask

  task automatic post(input int i, input logic wr,
                      input logic [31:0] a, input logic [31:0] d);
    req_write[i]        = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req[i]              = 1'b1;
  endtask

  task automatic xfer(input int i, input logic wr,
                      input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [N-1:0] dn);
    post(i, wr, a, d);
    lat = 99;
    dn  = '0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (done != '0) begin
        lat = k;
        dn  = done;
        break;
      end
    end
    if (lat == 99) req[i] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    srst_n  = 1'b0;
    hold    = '0;
    req     = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    tick();
    total_cnt++;
    if ({done, busy, psel, penable, pwrite} !== '0) begin
      $display("FAIL reset_ctrl got done=%b busy=%b psel=%b pen=%b pwr=%b want 0",
               done, busy, psel, penable, pwrite);
    end else pass_cnt++;
    total_cnt++;
    if ({paddr, pwdata, rdata} !== '0)
      $display("FAIL reset_data got paddr=%h pwdata=%h rdata=%h want 0",
               paddr, pwdata, rdata);
    else pass_cnt++;
    presetn = 1'b1;
    srst_n  = 1'b1;
    tick();
    tick();
    total_cnt++;
    if ({busy, psel, done} !== '0)
      $display("FAIL idle_no_req got busy=%b psel=%b done=%b want 0",
               busy, psel, done);
    else pass_cnt++;
  endtask

  task automatic test_single_write();
    post(0, 1'b1, ADDR_REG1, 32'hDEADBEEF);
    tick();
    total_cnt++;
    if ({psel, penable, busy, pwrite} !== 4'b1011 || paddr !== ADDR_REG1 ||
        pwdata !== 32'hDEADBEEF)
      $display("FAIL wr_setup got psel=%b pen=%b busy=%b pwr=%b paddr=%h pwdata=%h",
               psel, penable, busy, pwrite, paddr, pwdata);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({psel, penable, done} !== {2'b11, 4'b0000})
      $display("FAIL wr_access got psel=%b pen=%b done=%b want 1 1 0000",
               psel, penable, done);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({psel, penable, busy, done} !== {3'b001, 4'b0001})
      $display("FAIL wr_complete got psel=%b pen=%b busy=%b done=%b want 0 0 1 0001",
               psel, penable, busy, done);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy, done} !== 5'b0 || paddr !== ADDR_REG1 || pwrite !== 1'b1)
      $display("FAIL wr_idle_hold got busy=%b done=%b paddr=%h pwr=%b",
               busy, done, paddr, pwrite);
    else pass_cnt++;
    total_cnt++;
    if (m_reg1 !== 32'hDEADBEEF)
      $display("FAIL wr_reg1 got %h want deadbeef", m_reg1);
    else pass_cnt++;
  endtask

  task automatic test_single_read();
    int lat;
    logic [N-1:0] dn;
    post(1, 1'b0, ADDR_REG1, 32'h0);
    for (int k = 1; k <= 3; k++) tick();
    total_cnt++;
    if (done !== 4'b0000 || busy !== 1'b1 || psel !== 1'b0)
      $display("FAIL rd_rdwait got done=%b busy=%b psel=%b want 0000 1 0",
               done, busy, psel);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 4'b0010 || rdata !== 32'hDEADBEEF)
      $display("FAIL rd_reg1 got done=%b rdata=%h want 0010 deadbeef",
               done, rdata);
    else pass_cnt++;
    tick();
    xfer(0, 1'b1, ADDR_CNTRL, 32'hFFFFFFFF, lat, dn);
    xfer(2, 1'b0, ADDR_CNTRL, 32'h0, lat, dn);
    total_cnt++;
    if (lat !== 4 || dn !== 4'b0100 || rdata !== 32'h0000000F)
      $display("FAIL rd_cntrl got lat=%0d done=%b rdata=%h want 4 0100 0000000f",
               lat, dn, rdata);
    else pass_cnt++;
  endtask

  task automatic test_unmapped();
    int lat;
    logic [N-1:0] dn;
    xfer(3, 1'b0, ADDR_REG1, 32'h0, lat, dn);
    total_cnt++;
    if (dn !== 4'b1000 || rdata !== 32'hDEADBEEF)
      $display("FAIL rd3_reg1 got done=%b rdata=%h want 1000 deadbeef", dn, rdata);
    else pass_cnt++;
    xfer(0, 1'b0, ADDR_REG4, 32'h0, lat, dn);
    total_cnt++;
    if (lat !== 4 || dn !== 4'b0001 || rdata !== 32'h0)
      $display("FAIL rd_reg4_reset got lat=%0d done=%b rdata=%h want 4 0001 0",
               lat, dn, rdata);
    else pass_cnt++;
    xfer(1, 1'b0, ADDR_REG1, 32'h0, lat, dn);
    xfer(2, 1'b0, 32'h20, 32'h0, lat, dn);
    total_cnt++;
    if (lat !== 4 || dn !== 4'b0100 || rdata !== 32'h0)
      $display("FAIL rd_unmapped got lat=%0d done=%b rdata=%h want 4 0100 0",
               lat, dn, rdata);
    else pass_cnt++;
    xfer(3, 1'b0, ADDR_CNTRL, 32'h0, lat, dn);
    total_cnt++;
    if (dn !== 4'b1000 || rdata !== 32'hF)
      $display("FAIL rd3_cntrl got done=%b rdata=%h want 1000 f", dn, rdata);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int c0;
    done_log.delete();
    done_cyc.delete();
    for (int i = 0; i < N; i++) post(i, 1'b1, ADDR_REG2, 32'(i));
    c0 = cyc;
    for (int k = 0; k < 40 && done_log.size() < 4; k++) tick();
    tick();
    total_cnt++;
    if (done_log.size() != 4)
      $display("FAIL contention_count got %0d want 4", done_log.size());
    else begin
      if (done_log[0] != 0 || done_log[1] != 1 ||
          done_log[2] != 2 || done_log[3] != 3)
        $display("FAIL contention_order got %0d %0d %0d %0d want 0 1 2 3",
                 done_log[0], done_log[1], done_log[2], done_log[3]);
      else pass_cnt++;
      total_cnt++;
      if (done_cyc[0] - c0 != 3 || done_cyc[1] - c0 != 7 ||
          done_cyc[2] - c0 != 11 || done_cyc[3] - c0 != 15)
        $display("FAIL contention_timing got %0d %0d %0d %0d want 3 7 11 15",
                 done_cyc[0] - c0, done_cyc[1] - c0,
                 done_cyc[2] - c0, done_cyc[3] - c0);
      else pass_cnt++;
    end
    total_cnt++;
    if (m_reg2 !== 32'd3)
      $display("FAIL contention_reg2 got %h want 3", m_reg2);
    else pass_cnt++;
    done_log.delete();
    done_cyc.delete();
    post(3, 1'b0, ADDR_REG2, 32'h0);
    post(0, 1'b0, ADDR_REG2, 32'h0);
    for (int k = 0; k < 30 && done_log.size() < 2; k++) tick();
    tick();
    total_cnt++;
    if (done_log.size() != 2 || done_log[0] != 0 || done_log[1] != 3)
      $display("FAIL ptr_wrap got n=%0d first=%0d want 2 dones 0 then 3",
               done_log.size(), done_log.size() > 0 ? done_log[0] : -1);
    else pass_cnt++;
  endtask

  task automatic test_fairness();
    done_log.delete();
    done_cyc.delete();
    hold[1] = 1'b1;
    post(1, 1'b0, ADDR_REG1, 32'h0);
    for (int k = 1; k <= 30 && done_log.size() < 3; k++) begin
      tick();
      if (k == 1) post(3, 1'b0, ADDR_CNTRL, 32'h0);
      if (done_log.size() == 3) begin
        hold[1] = 1'b0;
        req[1]  = 1'b0;
      end
    end
    hold[1] = 1'b0;
    req     = '0;
    tick();
    total_cnt++;
    if (done_log.size() != 3 || done_log[0] != 1 ||
        done_log[1] != 3 || done_log[2] != 1)
      $display("FAIL fairness got n=%0d want order 1 3 1", done_log.size());
    else pass_cnt++;
    total_cnt++;
    if (rdata !== 32'hDEADBEEF || busy !== 1'b0)
      $display("FAIL fairness_end got rdata=%h busy=%b want deadbeef 0",
               rdata, busy);
    else pass_cnt++;
  endtask

  task automatic test_withdraw();
    int lat;
    post(1, 1'b1, ADDR_REG4, 32'hA5A5A5A5);
    tick();
    req[1] = 1'b0;
    lat = 99;
    for (int k = 2; k <= 10; k++) begin
      tick();
      if (done != '0) begin
        lat = k;
        total_cnt++;
        if (done !== 4'b0010)
          $display("FAIL withdraw_done got %b want 0010", done);
        else pass_cnt++;
        break;
      end
    end
    tick();
    total_cnt++;
    if (lat != 3 || m_reg4 !== 32'hA5A5A5A5 || paddr !== ADDR_REG4)
      $display("FAIL withdraw got lat=%0d reg4=%h paddr=%h want 3 a5a5a5a5 10",
               lat, m_reg4, paddr);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    post(2, 1'b1, ADDR_REG3, 32'h12345678);
    tick();
    tick();
    total_cnt++;
    if ({psel, penable} !== 2'b11)
      $display("FAIL mid_access got psel=%b pen=%b want 11", psel, penable);
    else pass_cnt++;
    presetn = 1'b0;
    req     = '0;
    #1;
    total_cnt++;
    if ({psel, penable, busy, done} !== '0)
      $display("FAIL mid_reset got psel=%b pen=%b busy=%b done=%b want 0",
               psel, penable, busy, done);
    else pass_cnt++;
    tick();
    tick();
    presetn = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (m_reg3 !== 32'h0 || done_log.size() != 0)
      $display("FAIL mid_abort got reg3=%h stray_done=%0d want 0 0",
               m_reg3, done_log.size());
    else pass_cnt++;
    post(2, 1'b0, ADDR_REG3, 32'h0);
    post(1, 1'b0, ADDR_REG3, 32'h0);
    for (int k = 0; k < 30 && done_log.size() < 2; k++) tick();
    tick();
    total_cnt++;
    if (done_log.size() != 2 || done_log[0] != 1 || done_log[1] != 2 ||
        rdata !== 32'h0)
      $display("FAIL post_reset_ptr got n=%0d first=%0d rdata=%h want 1 then 2, 0",
               done_log.size(), done_log.size() > 0 ? done_log[0] : -1, rdata);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_unmapped();
    test_back_to_back();
    test_fairness();
    test_withdraw();
    done_log.delete();
    done_cyc.delete();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
